// File: rtl/kira_pe_pkg.sv
// Shared PE definitions: neighbour direction encoding and the register-file
// port addresses that map onto the neighbour receive queues.
package kira_pe_pkg;

   localparam int NUM_DIR = 4;

   typedef enum logic [1:0] {
      DIR_N = 2'd0,
      DIR_S = 2'd1,
      DIR_E = 2'd2,
      DIR_W = 2'd3
   } dir_e;

   localparam logic [4:0] IN_NORTH = 5'd31;
   localparam logic [4:0] IN_SOUTH = 5'd30;
   localparam logic [4:0] IN_WEST  = 5'd29;
   localparam logic [4:0] IN_EAST  = 5'd28;

   // Source-operand address that reads the queue of a given direction.
   function automatic logic [4:0] dir2addr(input dir_e d);
      logic [4:0] addr;
      unique case (d)
         DIR_N:   addr = IN_NORTH;
         DIR_S:   addr = IN_SOUTH;
         DIR_E:   addr = IN_EAST;
         default: addr = IN_WEST;
      endcase
      return addr;
   endfunction

endpackage

// File: rtl/nbr_fifo.sv
// Single-direction receive FIFO: power-of-two depth, combinational head,
// occupancy counter, synchronous flush that discards same-cycle push/pop.
module nbr_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush_i,
   input  logic                         push_i,
   input  logic [DATA_W-1:0]            wdata_i,
   input  logic                         pop_i,
   output logic [DATA_W-1:0]            head_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   occ_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH+1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic              do_push, do_pop;

   assign full_o  = (occ_q == OCC_W'(DEPTH));
   assign empty_o = (occ_q == '0);
   assign occ_o   = occ_q;

   // A full FIFO refuses a push even when it is popped in the same cycle.
   assign do_push = push_i && !full_o  && !flush_i;
   assign do_pop  = pop_i  && !empty_o && !flush_i;

   // Next-state for pointers and occupancy; pointers wrap naturally (power-of-two depth).
   always_comb begin
      // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         unique case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Storage write.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; the head is masked to zero while empty.
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/nbr_in_buf.sv
// Per-PE neighbour receive buffer: four direction FIFOs, operand demand decode,
// all-or-nothing pop on issue, and the stall towards the issue stage.
// Optional same-cycle bypass of an incoming word into an empty queue is built
// when the macro NBR_BYPASS_EN is defined.
module nbr_in_buf
   import kira_pe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  flush,
   input  logic [NUM_DIR*DATA_W-1:0]             lnk_data,
   input  logic [NUM_DIR-1:0]                    lnk_valid,
   output logic [NUM_DIR-1:0]                    lnk_ready,
   input  logic [4:0]                            ra1,
   input  logic [4:0]                            ra2,
   input  logic                                  rs1_used,
   input  logic                                  rs2_used,
   input  logic                                  issue,
   output logic [DATA_W-1:0]                     i_n,
   output logic [DATA_W-1:0]                     i_s,
   output logic [DATA_W-1:0]                     i_e,
   output logic [DATA_W-1:0]                     i_w,
   output logic                                  nbr_stall,
   output logic [NUM_DIR*$clog2(DEPTH+1)-1:0]    occ
);

   localparam int OCC_W = $clog2(DEPTH+1);

   logic [NUM_DIR-1:0] full, empty, push, pop;
   logic [NUM_DIR-1:0] req, byp_avail, empty_avail, byp_use;
   logic [DATA_W-1:0]  fifo_head [NUM_DIR];
   logic [DATA_W-1:0]  head      [NUM_DIR];

   // Demand decode and bypass availability per direction.
   always_comb begin
      req         = '0;
      byp_avail   = '0;
      empty_avail = '0;
      for (int d = 0; d < NUM_DIR; d++) begin
         req[d] = issue &&
                  ((rs1_used && (ra1 == dir2addr(dir_e'(2'(d))))) ||
                   (rs2_used && (ra2 == dir2addr(dir_e'(2'(d))))));
`ifdef NBR_BYPASS_EN
         byp_avail[d] = empty[d] && lnk_valid[d];
`else
         byp_avail[d] = 1'b0;
`endif
         empty_avail[d] = empty[d] && !byp_avail[d];
      end
   end

   assign nbr_stall = |(req & empty_avail);

   // Pop fan-out, bypass consumption and head selection.
   always_comb begin
      pop     = '0;
      push    = '0;
      byp_use = '0;
      for (int d = 0; d < NUM_DIR; d++) begin
         byp_use[d] = byp_avail[d] && req[d] && !nbr_stall;
         pop[d]     = req[d] && !nbr_stall && !empty[d];
         push[d]    = lnk_valid[d] && !byp_use[d];
         head[d]    = byp_avail[d] ? lnk_data[d*DATA_W +: DATA_W] : fifo_head[d];
      end
   end

   for (genvar g = 0; g < NUM_DIR; g++) begin : g_dir
      nbr_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .flush_i (flush),
         .push_i  (push[g]),
         .wdata_i (lnk_data[g*DATA_W +: DATA_W]),
         .pop_i   (pop[g]),
         .head_o  (fifo_head[g]),
         .full_o  (full[g]),
         .empty_o (empty[g]),
         .occ_o   (occ[g*OCC_W +: OCC_W])
      );
   end

   // Ready depends only on registered occupancy, never on this cycle's pop.
   assign lnk_ready = ~full;

   assign i_n = head[DIR_N];
   assign i_s = head[DIR_S];
   assign i_e = head[DIR_E];
   assign i_w = head[DIR_W];

endmodule
